// File: rtl/bcd_cascade_counter.sv
// rtl/bcd_cascade_counter.sv - multi-digit BCD up/down cascade counter with validated load
//
// Purpose: DIGITS-decade BCD counter stepped by an upstream carry pulse (en).
//          Digits ripple internally within one cycle; a registered carry pulse
//          marks each full wrap so further stages can be chained.
// Ports:
//   clk      - system clock, rising edge
//   reset    - synchronous, active-high clear of all state
//   en       - count enable, one step per cycle while high
//   d        - direction: 0 = up, 1 = down
//   load     - parallel load request
//   load_val - BCD load value, digit 0 in bits [3:0]
//   count    - registered BCD count, digit 0 in bits [3:0]
//   carry    - registered one-cycle wrap pulse
//   zero     - combinational, count == 0
//   load_err - registered one-cycle pulse when a load value is not BCD
module bcd_cascade_counter #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                d,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] count,
    output logic                carry,
    output logic                zero,
    output logic                load_err
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0] count_q, count_d;
    logic         carry_q, carry_d;
    logic         load_err_q, load_err_d;

    logic [W-1:0] step_val;
    logic [3:0]   nib;
    logic         ripple;
    logic         load_ok;

    // Per-digit step: a digit moves only while every lower digit sits at its
    // rollover value (9 going up, 0 going down). After the loop, ripple is set
    // exactly when all digits were at rollover, i.e. the whole counter wraps.
    always_comb begin
        step_val = count_q;
        ripple   = 1'b1;
        nib      = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            nib = count_q[4*i +: 4];
            if (ripple) begin
                if (!d) begin
                    step_val[4*i +: 4] = (nib == 4'd9) ? 4'd0 : nib + 4'd1;
                end else begin
                    step_val[4*i +: 4] = (nib == 4'd0) ? 4'd9 : nib - 4'd1;
                end
            end
            ripple = ripple & (d ? (nib == 4'd0) : (nib == 4'd9));
        end
    end

    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                load_ok = 1'b0;
            end
        end
    end

    // Load has priority over stepping; a rejected load still swallows en.
    always_comb begin
        count_d    = count_q;
        carry_d    = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            if (load_ok) begin
                count_d = load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (en) begin
            count_d = step_val;
            carry_d = ripple;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            carry_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            carry_q    <= carry_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign carry    = carry_q;
    assign load_err = load_err_q;
    assign zero     = (count_q == '0);

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// tb/tb_bcd_cascade_counter.sv - self-checking bench for bcd_cascade_counter
module tb_bcd_cascade_counter;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int MODV   = 10000;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         en = 1'b0;
    logic         d = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] count;
    logic         carry;
    logic         zero;
    logic         load_err;

    int total = 0;
    int bad   = 0;

    // Reference state: plain integer value of the counter plus pulse flags.
    int m_val   = 0;
    bit m_carry = 1'b0;
    bit m_err   = 1'b0;
    bit armed   = 1'b0;

    bcd_cascade_counter #(.DIGITS(DIGITS)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .d        (d),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .carry    (carry),
        .zero     (zero),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit is_bcd(input logic [W-1:0] b);
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int from_bcd(input logic [W-1:0] b);
        int v;
        v = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            v = v * 10 + int'(b[4*i +: 4]);
        end
        return v;
    endfunction

    // Model update on each rising edge from the inputs held across that edge.
    always @(posedge clk) begin
        m_carry = 1'b0;
        m_err   = 1'b0;
        if (reset) begin
            m_val = 0;
            armed = 1'b1;
        end else if (load) begin
            if (is_bcd(load_val)) m_val = from_bcd(load_val);
            else                  m_err = 1'b1;
        end else if (en) begin
            if (!d) begin
                m_carry = (m_val == MODV - 1);
                m_val   = (m_val + 1) % MODV;
            end else begin
                m_carry = (m_val == 0);
                m_val   = (m_val + MODV - 1) % MODV;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (armed) begin
            total++;
            if (count !== to_bcd(m_val) || carry !== m_carry ||
                load_err !== m_err || zero !== (m_val == 0)) begin
                bad++;
                $display("FAIL model t=%0t count=%h carry=%b err=%b zero=%b expected count=%h carry=%b err=%b zero=%b",
                         $time, count, carry, load_err, zero, to_bcd(m_val), m_carry, m_err, (m_val == 0));
            end
        end
    end

    task automatic cyc(input logic r, input logic l, input logic [W-1:0] lv,
                       input logic e, input logic dir);
        reset    = r;
        load     = l;
        load_val = lv;
        en       = e;
        d        = dir;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_lit(input string name, input logic [W-1:0] c_exp,
                              input logic cy_exp, input logic er_exp);
        total++;
        if (count !== c_exp || carry !== cy_exp || load_err !== er_exp) begin
            bad++;
            $display("FAIL %s count=%h carry=%b err=%b expected count=%h carry=%b err=%b",
                     name, count, carry, load_err, c_exp, cy_exp, er_exp);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset wins over load and en in the same cycle.
        cyc(1, 1, 16'h1234, 1, 0);
        expect_lit("reset_over_load", 16'h0000, 0, 0);
        total++;
        if (zero !== 1'b1) begin
            bad++;
            $display("FAIL reset_zero zero=%b expected 1", zero);
        end
        for (int i = 0; i < 5; i++) cyc(0, 0, '0, 0, 0);
        expect_lit("idle_hold", 16'h0000, 0, 0);

        // Up across the wrap.
        cyc(0, 1, 16'h9998, 0, 0);
        cyc(0, 0, '0, 1, 0); expect_lit("up_9999", 16'h9999, 0, 0);
        cyc(0, 0, '0, 1, 0); expect_lit("up_wrap", 16'h0000, 1, 0);
        cyc(0, 0, '0, 1, 0); expect_lit("up_0001", 16'h0001, 0, 0);

        // Down across the wrap.
        cyc(0, 1, 16'h0001, 0, 0);
        cyc(0, 0, '0, 1, 1); expect_lit("dn_0000", 16'h0000, 0, 0);
        cyc(0, 0, '0, 1, 1); expect_lit("dn_wrap", 16'h9999, 1, 0);
        cyc(0, 0, '0, 1, 1); expect_lit("dn_9998", 16'h9998, 0, 0);

        // Internal ripple.
        cyc(0, 1, 16'h0099, 0, 0);
        cyc(0, 0, '0, 1, 0); expect_lit("ripple_up", 16'h0100, 0, 0);
        cyc(0, 1, 16'h1000, 0, 0);
        cyc(0, 0, '0, 1, 1); expect_lit("ripple_dn", 16'h0999, 0, 0);

        // Rejected load, with en also high.
        cyc(0, 1, 16'h0057, 0, 0);
        cyc(0, 1, 16'h12A4, 1, 0); expect_lit("bad_load", 16'h0057, 0, 1);
        cyc(0, 0, '0, 0, 0);       expect_lit("bad_load_clr", 16'h0057, 0, 0);
        cyc(0, 1, 16'hF000, 0, 1); expect_lit("bad_load_top", 16'h0057, 0, 1);

        // Load beats en.
        cyc(0, 1, 16'h0500, 1, 0); expect_lit("load_over_en", 16'h0500, 0, 0);
        cyc(0, 0, '0, 1, 0);       expect_lit("after_load", 16'h0501, 0, 0);

        // Direction change without latency.
        cyc(0, 0, '0, 1, 1);       expect_lit("dir_flip", 16'h0500, 0, 0);

        // en held across several wraps, both directions, checked by the model.
        cyc(0, 1, 16'h9990, 0, 0);
        for (int i = 0; i < 25; i++) cyc(0, 0, '0, 1, 0);
        expect_lit("held_up", 16'h0015, 0, 0);
        for (int i = 0; i < 40; i++) cyc(0, 0, '0, (i % 3) != 0, 1);
        for (int i = 0; i < 20; i++) cyc(0, 0, '0, 1, i[0]);

        // Reset mid-count with en high.
        cyc(0, 1, 16'h4321, 0, 0);
        cyc(1, 0, '0, 1, 0);       expect_lit("reset_mid", 16'h0000, 0, 0);
        cyc(0, 0, '0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
